// File: rtl/counter_pkg.sv
// Shared constants and helpers for the modulo counter family.
package counter_pkg;

    // Direction encoding on the dir input
    localparam logic DIR_UP   = 1'b1;
    localparam logic DIR_DOWN = 1'b0;

    // Limit behaviour selected by the SATURATE parameter
    localparam int MODE_WRAP = 0;
    localparam int MODE_SAT  = 1;

    // Wide enough for any supported WIDTH (<= 31) plus one guard bit
    localparam int CALC_W = 33;
    typedef logic [CALC_W-1:0] calc_t;

    // Out-of-range load values are pinned to the top of the range
    function automatic calc_t clamp_load(input calc_t val, input calc_t mod);
        return (val < mod) ? val : (mod - calc_t'(1));
    endfunction

endpackage

// File: rtl/mod_counter_next.sv
// Combinational next-state logic for mod_counter: priority clr > load > en,
// wrap or saturate at the range limits, limit detection for tc/wrap/ovf.
module mod_counter_next
    import counter_pkg::*;
#(
    parameter int WIDTH    = 8,
    parameter int MOD      = 256,
    parameter int SATURATE = 0
) (
    input  logic [WIDTH-1:0] count,
    input  logic             dir,
    input  logic             en,
    input  logic             clr,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] next_count,
    output logic             limit_hit
);

    // Compares are done one bit wider so MOD == 2**WIDTH has no truncation
    localparam logic [WIDTH:0] MAX_X = (WIDTH+1)'(MOD - 1);
    localparam logic [WIDTH:0] ONE_X = (WIDTH+1)'(1);

    logic [WIDTH:0]   cnt_x;
    logic [WIDTH:0]   up_x;
    logic [WIDTH:0]   dn_x;
    logic             at_max;
    logic             at_zero;
    logic [WIDTH-1:0] loaded;

    assign cnt_x   = {1'b0, count};
    assign up_x    = cnt_x + ONE_X;
    assign dn_x    = cnt_x - ONE_X;
    assign at_max  = (cnt_x == MAX_X);
    assign at_zero = (cnt_x == '0);
    assign loaded  = WIDTH'(clamp_load(calc_t'(load_val), calc_t'(MOD)));

    // Select the next count and flag a limit crossing in the same pass
    always_comb begin
        next_count = count;
        limit_hit  = 1'b0;
        if (clr) begin
            next_count = '0;
        end else if (load) begin
            next_count = loaded;
        end else if (en) begin
            if (dir == DIR_UP) begin
                if (at_max) begin
                    limit_hit  = 1'b1;
                    next_count = (SATURATE == MODE_SAT) ? count : '0;
                end else begin
                    next_count = up_x[WIDTH-1:0];
                end
            end else begin
                if (at_zero) begin
                    limit_hit  = 1'b1;
                    next_count = (SATURATE == MODE_SAT) ? count : MAX_X[WIDTH-1:0];
                end else begin
                    next_count = dn_x[WIDTH-1:0];
                end
            end
        end
    end

endmodule

// File: rtl/mod_counter.sv
// Parametrised up/down modulo counter with clear, load, enable, terminal
// count, registered wrap pulse and sticky overflow flag.
module mod_counter
    import counter_pkg::*;
#(
    parameter int WIDTH    = 8,
    parameter int MOD      = 256,
    parameter int SATURATE = 0,
    parameter int RST_VAL  = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             dir,
    input  logic             clr,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] count,
    output logic             tc,
    output logic             wrap,
    output logic             ovf
);

    // Reject parameter sets the counter cannot represent
    if (WIDTH < 1 || WIDTH > 31) begin : g_bad_width
        $error("mod_counter: WIDTH must be in 1..31");
    end
    if (MOD < 2 || longint'(MOD) > (longint'(1) << WIDTH)) begin : g_bad_mod
        $error("mod_counter: MOD must satisfy 2 <= MOD <= 2**WIDTH");
    end
    if (RST_VAL < 0 || RST_VAL >= MOD) begin : g_bad_rst
        $error("mod_counter: RST_VAL must be in 0..MOD-1");
    end

    localparam logic [WIDTH-1:0] RST_CNT = WIDTH'(RST_VAL);

    logic [WIDTH-1:0] count_q, count_d;
    logic             wrap_q, wrap_d;
    logic             ovf_q, ovf_d;
    logic             limit_hit;

    mod_counter_next #(
        .WIDTH    (WIDTH),
        .MOD      (MOD),
        .SATURATE (SATURATE)
    ) u_next (
        .count      (count_q),
        .dir        (dir),
        .en         (en),
        .clr        (clr),
        .load       (load),
        .load_val   (load_val),
        .next_count (count_d),
        .limit_hit  (limit_hit)
    );

    // wrap follows each limit event; ovf accumulates until clr
    always_comb begin
        wrap_d = limit_hit;
        ovf_d  = clr ? 1'b0 : (ovf_q | limit_hit);
    end

    // State registers with immediate reset on rst low
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_q <= RST_CNT;
            wrap_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            count_q <= count_d;
            wrap_q  <= wrap_d;
            ovf_q   <= ovf_d;
        end
    end

    // limit_hit is already gated by en/clr/load, so it is the predictor
    assign tc    = limit_hit;
    assign count = count_q;
    assign wrap  = wrap_q;
    assign ovf   = ovf_q;

endmodule

// File: tb/tb_mod_counter.sv
// Bench for mod_counter: three instances share stimulus
//   0: MOD=256 wrap RST_VAL=0, 1: MOD=10 wrap RST_VAL=5, 2: MOD=10 saturate RST_VAL=0
module tb_mod_counter;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       en = 1'b0, dir = 1'b0, clr = 1'b0, load = 1'b0;
    logic [7:0] load_val = 8'd0;

    logic [2:0][7:0] cnt_o;
    logic [2:0]      tc_o, wrap_o, ovf_o;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    mod_counter #(.WIDTH(8), .MOD(256), .SATURATE(0), .RST_VAL(0)) dut0 (
        .clk(clk), .rst(rst), .en(en), .dir(dir), .clr(clr), .load(load),
        .load_val(load_val), .count(cnt_o[0]), .tc(tc_o[0]), .wrap(wrap_o[0]), .ovf(ovf_o[0]));
    mod_counter #(.WIDTH(8), .MOD(10), .SATURATE(0), .RST_VAL(5)) dut1 (
        .clk(clk), .rst(rst), .en(en), .dir(dir), .clr(clr), .load(load),
        .load_val(load_val), .count(cnt_o[1]), .tc(tc_o[1]), .wrap(wrap_o[1]), .ovf(ovf_o[1]));
    mod_counter #(.WIDTH(8), .MOD(10), .SATURATE(1), .RST_VAL(0)) dut2 (
        .clk(clk), .rst(rst), .en(en), .dir(dir), .clr(clr), .load(load),
        .load_val(load_val), .count(cnt_o[2]), .tc(tc_o[2]), .wrap(wrap_o[2]), .ovf(ovf_o[2]));

    function automatic int mod_of(input int i);
        return (i == 0) ? 256 : 10;
    endfunction
    function automatic bit sat_of(input int i);
        return (i == 2);
    endfunction
    function automatic int rst_of(input int i);
        return (i == 1) ? 5 : 0;
    endfunction

    // Reference model: the behavioural rules applied to integers
    int m_cnt[3];
    bit m_wrap[3];
    bit m_ovf[3];

    always @(posedge clk or negedge rst) begin
        for (int i = 0; i < 3; i++) begin
            if (!rst) begin
                m_cnt[i] = rst_of(i); m_wrap[i] = 0; m_ovf[i] = 0;
            end else if (clr) begin
                m_cnt[i] = 0; m_wrap[i] = 0; m_ovf[i] = 0;
            end else if (load) begin
                m_cnt[i]  = (int'(load_val) < mod_of(i)) ? int'(load_val) : mod_of(i) - 1;
                m_wrap[i] = 0;
            end else if (en) begin
                if ((dir && m_cnt[i] == mod_of(i) - 1) || (!dir && m_cnt[i] == 0)) begin
                    m_wrap[i] = 1; m_ovf[i] = 1;
                    if (!sat_of(i)) m_cnt[i] = dir ? 0 : mod_of(i) - 1;
                end else begin
                    m_wrap[i] = 0;
                    m_cnt[i]  = dir ? m_cnt[i] + 1 : m_cnt[i] - 1;
                end
            end else begin
                m_wrap[i] = 0;
            end
        end
    end

    function automatic bit model_tc(input int i);
        return en && !clr && !load &&
               ((dir && m_cnt[i] == mod_of(i) - 1) || (!dir && m_cnt[i] == 0));
    endfunction

    task automatic cycle();
        @(posedge clk);
        #2;
    endtask

    task automatic test_reset();
        #12;
        for (int i = 0; i < 3; i++) begin
            n_tests++;
            if ({cnt_o[i], wrap_o[i], ovf_o[i]} !== {8'(rst_of(i)), 1'b0, 1'b0}) begin
                n_fail++;
                $display("FAIL reset_state dut%0d got cnt=%0d wrap=%b ovf=%b exp cnt=%0d wrap=0 ovf=0",
                         i, cnt_o[i], wrap_o[i], ovf_o[i], rst_of(i));
            end
            $display("[TB] reset dut%0d count=%0d", i, cnt_o[i]);
        end
        rst = 1'b1;
    endtask

    // Full-range up sweep on the MOD=256 instance
    task automatic test_sweep();
        en = 1'b1; dir = 1'b1;
        #1;
        for (int k = 1; k <= 260; k++) begin
            n_tests++;
            if (tc_o[0] !== (((k - 1) % 256) == 255)) begin
                n_fail++;
                $display("FAIL sweep_tc k=%0d got=%b exp=%b", k, tc_o[0], ((k - 1) % 256) == 255);
            end
            cycle();
            n_tests++;
            if ({cnt_o[0], wrap_o[0], ovf_o[0]} !== {8'(k % 256), 1'(k == 256), 1'(k >= 256)}) begin
                n_fail++;
                $display("FAIL sweep k=%0d got cnt=%0d wrap=%b ovf=%b exp cnt=%0d wrap=%b ovf=%b",
                         k, cnt_o[0], wrap_o[0], ovf_o[0], k % 256, k == 256, k >= 256);
            end
        end
        $display("[TB] sweep done count=%0d ovf=%b", cnt_o[0], ovf_o[0]);
        en = 1'b0;
    endtask

    // Down-wrap from 0 on MOD=10 wrap instance, then clear
    task automatic test_wrap_down();
        clr = 1'b1; cycle(); clr = 1'b0;
        en = 1'b1; dir = 1'b0;
        #1;
        n_tests++;
        if (tc_o[1] !== 1'b1) begin
            n_fail++; $display("FAIL wrapdn_tc got=%b exp=1", tc_o[1]);
        end
        cycle();
        en = 1'b0;
        n_tests++;
        if ({cnt_o[1], wrap_o[1], ovf_o[1]} !== {8'd9, 1'b1, 1'b1}) begin
            n_fail++;
            $display("FAIL wrapdn_edge got cnt=%0d wrap=%b ovf=%b exp cnt=9 wrap=1 ovf=1",
                     cnt_o[1], wrap_o[1], ovf_o[1]);
        end
        $display("[TB] wrap down count=%0d", cnt_o[1]);
        cycle();
        n_tests++;
        if ({cnt_o[1], wrap_o[1], ovf_o[1]} !== {8'd9, 1'b0, 1'b1}) begin
            n_fail++;
            $display("FAIL wrapdn_hold got cnt=%0d wrap=%b ovf=%b exp cnt=9 wrap=0 ovf=1",
                     cnt_o[1], wrap_o[1], ovf_o[1]);
        end
        clr = 1'b1; cycle(); clr = 1'b0;
        n_tests++;
        if ({cnt_o[1], wrap_o[1], ovf_o[1]} !== {8'd0, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL wrapdn_clr got cnt=%0d wrap=%b ovf=%b exp cnt=0 wrap=0 ovf=0",
                     cnt_o[1], wrap_o[1], ovf_o[1]);
        end
        $display("[TB] clear count=%0d ovf=%b", cnt_o[1], ovf_o[1]);
    endtask

    // Saturating instance held at the top limit
    task automatic test_saturate();
        clr = 1'b1; cycle(); clr = 1'b0;
        en = 1'b1; dir = 1'b1;
        for (int k = 1; k <= 15; k++) begin
            cycle();
            n_tests++;
            if ({cnt_o[2], wrap_o[2], ovf_o[2]} !== {8'((k < 9) ? k : 9), 1'(k >= 10), 1'(k >= 10)}) begin
                n_fail++;
                $display("FAIL sat k=%0d got cnt=%0d wrap=%b ovf=%b exp cnt=%0d wrap=%b ovf=%b",
                         k, cnt_o[2], wrap_o[2], ovf_o[2], (k < 9) ? k : 9, k >= 10, k >= 10);
            end
        end
        $display("[TB] saturate count=%0d wrap=%b", cnt_o[2], wrap_o[2]);
        en = 1'b0;
    endtask

    task automatic test_load();
        en = 1'b0; load = 1'b1; load_val = 8'd7;
        cycle();
        n_tests++;
        if (cnt_o[1] !== 8'd7) begin
            n_fail++; $display("FAIL load7 got=%0d exp=7", cnt_o[1]);
        end
        $display("[TB] load 7 count=%0d", cnt_o[1]);
        load_val = 8'd200;
        cycle();
        n_tests++;
        if ({cnt_o[1], cnt_o[0]} !== {8'd9, 8'd200}) begin
            n_fail++; $display("FAIL load_clamp got=%0d/%0d exp=9/200", cnt_o[1], cnt_o[0]);
        end
        $display("[TB] load 200 count=%0d", cnt_o[1]);
        clr = 1'b1; load_val = 8'd7;
        cycle();
        clr = 1'b0;
        n_tests++;
        if (cnt_o[1] !== 8'd0) begin
            n_fail++; $display("FAIL load_clr got=%0d exp=0", cnt_o[1]);
        end
        load_val = 8'd4; en = 1'b1; dir = 1'b1;
        cycle();
        n_tests++;
        if ({cnt_o[1], cnt_o[2], wrap_o[1]} !== {8'd4, 8'd4, 1'b0}) begin
            n_fail++; $display("FAIL load_en got=%0d/%0d wrap=%b exp=4/4 wrap=0", cnt_o[1], cnt_o[2], wrap_o[1]);
        end
        $display("[TB] load with en count=%0d", cnt_o[1]);
        load = 1'b0; en = 1'b0;
    endtask

    task automatic test_dir_flip();
        int seq[4] = '{6, 7, 6, 5};
        load = 1'b1; load_val = 8'd5;
        cycle();
        load = 1'b0; en = 1'b1;
        for (int k = 0; k < 4; k++) begin
            dir = (k < 2);
            cycle();
            n_tests++;
            if (cnt_o[1] !== 8'(seq[k])) begin
                n_fail++; $display("FAIL dirflip step=%0d got=%0d exp=%0d", k, cnt_o[1], seq[k]);
            end
            $display("[TB] dir=%b count=%0d", dir, cnt_o[1]);
        end
        en = 1'b0;
    endtask

    // Constrained-random traffic against the reference model
    task automatic test_random();
        for (int k = 0; k < 400; k++) begin
            en   = ($urandom_range(0, 3) != 0);
            dir  = 1'($urandom_range(0, 1));
            clr  = ($urandom_range(0, 31) == 0);
            load = ($urandom_range(0, 15) == 0);
            load_val = ($urandom_range(0, 1) != 0) ? 8'($urandom_range(0, 15)) : 8'($urandom_range(0, 255));
            #1;
            for (int i = 0; i < 3; i++) begin
                n_tests++;
                if (tc_o[i] !== model_tc(i)) begin
                    n_fail++; $display("FAIL rand_tc k=%0d dut%0d got=%b exp=%b", k, i, tc_o[i], model_tc(i));
                end
            end
            cycle();
            for (int i = 0; i < 3; i++) begin
                n_tests++;
                if ({cnt_o[i], wrap_o[i], ovf_o[i]} !== {8'(m_cnt[i]), m_wrap[i], m_ovf[i]}) begin
                    n_fail++;
                    $display("FAIL rand k=%0d dut%0d got cnt=%0d wrap=%b ovf=%b exp cnt=%0d wrap=%b ovf=%b",
                             k, i, cnt_o[i], wrap_o[i], ovf_o[i], m_cnt[i], m_wrap[i], m_ovf[i]);
                end
            end
        end
        en = 1'b0; clr = 1'b0; load = 1'b0;
        $display("[TB] random phase done");
    endtask

    task automatic test_async_reset();
        load = 1'b1; load_val = 8'd255;
        cycle();
        load = 1'b0; en = 1'b1; dir = 1'b1;
        cycle();
        en = 1'b0; load = 1'b1; load_val = 8'd42;
        cycle();
        load = 1'b0;
        n_tests++;
        if ({cnt_o[0], ovf_o[0]} !== {8'd42, 1'b1}) begin
            n_fail++; $display("FAIL areset_pre got cnt=%0d ovf=%b exp cnt=42 ovf=1", cnt_o[0], ovf_o[0]);
        end
        #2;
        rst = 1'b0;
        #1;
        for (int i = 0; i < 3; i++) begin
            n_tests++;
            if ({cnt_o[i], wrap_o[i], ovf_o[i]} !== {8'(rst_of(i)), 1'b0, 1'b0}) begin
                n_fail++;
                $display("FAIL areset dut%0d got cnt=%0d wrap=%b ovf=%b exp cnt=%0d wrap=0 ovf=0",
                         i, cnt_o[i], wrap_o[i], ovf_o[i], rst_of(i));
            end
        end
        $display("[TB] async reset count=%0d", cnt_o[0]);
        #3;
        rst = 1'b1; en = 1'b1; dir = 1'b1;
        cycle();
        n_tests++;
        if ({cnt_o[0], cnt_o[1]} !== {8'd1, 8'd6}) begin
            n_fail++; $display("FAIL areset_release got=%0d/%0d exp=1/6", cnt_o[0], cnt_o[1]);
        end
        en = 1'b0;
    endtask

    initial begin
        test_reset();
        test_sweep();
        test_wrap_down();
        test_saturate();
        test_load();
        test_dir_flip();
        test_random();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
